// File: rtl/poco_dmem_pkg.sv
// Shared constants for the POCO data-memory responder: sizes, the
// memory-mapped register addresses and the STAT register bit layout.
package poco_dmem_pkg;

  localparam int DMEM_DATA_W = 16;
  localparam int DMEM_DEPTH  = 256;
  localparam int DMEM_FIFO_D = 4;

  localparam logic [15:0] ADDR_TXD  = 16'hFFF0;
  localparam logic [15:0] ADDR_STAT = 16'hFFF1;
  localparam logic [15:0] ADDR_TMR  = 16'hFFF2;

  localparam int STAT_EMPTY_BIT = 0;
  localparam int STAT_FULL_BIT  = 1;
  localparam int STAT_OVF_BIT   = 2;
  localparam int STAT_CNT_LSB   = 4;

endpackage

// File: rtl/poco_dmem_sync_fifo.sv
// Small synchronous FIFO with a separate occupancy count so that full and
// empty are distinguishable. Callers must only assert pop when non-empty.
module sync_fifo #(
  parameter int W = 16,
  parameter int D = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [W-1:0]     din,
  output logic [W-1:0]     dout,
  output logic             empty,
  output logic             full,
  output logic [$clog2(D):0] count
);

  localparam int PW = $clog2(D);
  localparam int CW = $clog2(D) + 1;

  logic [W-1:0]  mem_q [D];
  logic [PW-1:0] wrPtr_q;
  logic [PW-1:0] rdPtr_q;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage is cleared on reset so the head slot presents zero while empty.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
      for (int i = 0; i < D; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (push) begin
        mem_q[wrPtr_q] <= din;
        wrPtr_q        <= wrPtr_q + PW'(1);
      end
      if (pop) begin
        rdPtr_q <= rdPtr_q + PW'(1);
      end
      count_q <= count_d;
    end
  end

  assign dout  = mem_q[rdPtr_q];
  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(D));
  assign count = count_q;

endmodule

// File: rtl/poco_dmem.sv
// Data-memory responder for the POCO CPU: word RAM plus memory-mapped
// transmit FIFO (TXD), status (STAT) and free-running timer (TMR).
module poco_dmem
  import poco_dmem_pkg::*;
#(
  parameter int DATA_W = DMEM_DATA_W,
  parameter int DEPTH  = DMEM_DEPTH,
  parameter int FIFO_D = DMEM_FIFO_D
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] daddr,
  input  logic [DATA_W-1:0] ddataout,
  input  logic              we,
  output logic [DATA_W-1:0] ddatain,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(FIFO_D) + 1;

  logic [DATA_W-1:0] ram [DEPTH];
  logic              ovf_q, ovf_d;
  logic [15:0]       tmr_q, tmr_d;
  logic              isRam, isTxd, isStat, isTmr;
  logic              fifoPush, fifoPop, fifoEmpty, fifoFull;
  logic [CW-1:0]     fifoCount;
  logic [DATA_W-1:0] statWord;

  assign isRam  = (daddr < DATA_W'(DEPTH));
  assign isTxd  = (daddr == DATA_W'(ADDR_TXD));
  assign isStat = (daddr == DATA_W'(ADDR_STAT));
  assign isTmr  = (daddr == DATA_W'(ADDR_TMR));

  // A pop frees a slot in the same edge, so a full FIFO still takes the push.
  assign fifoPop   = !fifoEmpty && out_ready;
  assign fifoPush  = we && isTxd && (!fifoFull || fifoPop);
  assign out_valid = !fifoEmpty;

  sync_fifo #(
    .W (DATA_W),
    .D (FIFO_D)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifoPush),
    .pop   (fifoPop),
    .din   (ddataout),
    .dout  (out_data),
    .empty (fifoEmpty),
    .full  (fifoFull),
    .count (fifoCount)
  );

  always_comb begin
    ovf_d = ovf_q;
    if (we && isStat) ovf_d = 1'b0;
    if (we && isTxd && !fifoPush) ovf_d = 1'b1;
    tmr_d = tmr_q + 16'd1;
    if (we && isTmr) tmr_d = ddataout[15:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
      tmr_q <= '0;
    end else begin
      ovf_q <= ovf_d;
      tmr_q <= tmr_d;
    end
  end

  // RAM is deliberately not reset; contents are defined only once written.
  always_ff @(posedge clk) begin
    if (we && isRam) ram[daddr[AW-1:0]] <= ddataout;
  end

  always_comb begin
    statWord                             = '0;
    statWord[STAT_EMPTY_BIT]             = fifoEmpty;
    statWord[STAT_FULL_BIT]              = fifoFull;
    statWord[STAT_OVF_BIT]               = ovf_q;
    statWord[STAT_CNT_LSB +: CW]         = fifoCount;
  end

  always_comb begin
    ddatain = '0;
    if (isRam)       ddatain = ram[daddr[AW-1:0]];
    else if (isStat) ddatain = statWord;
    else if (isTmr)  ddatain = DATA_W'(tmr_q);
  end

endmodule

// File: tb/tb_poco_dmem.sv
// Directed self-checking bench for poco_dmem: RAM, TXD FIFO ordering,
// overflow, full-with-pop, timer wrap and reset in the middle of a drain.
module tb_poco_dmem;

  localparam logic [15:0] TXD  = 16'hFFF0;
  localparam logic [15:0] STAT = 16'hFFF1;
  localparam logic [15:0] TMR  = 16'hFFF2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] daddr;
  logic [15:0] ddataout;
  logic        we;
  logic [15:0] ddatain;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;

  int total = 0;
  int bad   = 0;

  poco_dmem dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .daddr     (daddr),
    .ddataout  (ddataout),
    .we        (we),
    .ddatain   (ddatain),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [15:0] obs,
                             input logic [15:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] addr, input logic [15:0] data,
                               input logic wr, input logic rdy);
    daddr     = addr;
    ddataout  = data;
    we        = wr;
    out_ready = rdy;
  endtask

  // Called at a falling edge; performs one write across the next rising edge.
  task automatic writeWord(input logic [15:0] addr, input logic [15:0] data);
    applyStimulus(addr, data, 1'b1, out_ready);
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic readCheck(input string tag, input logic [15:0] addr,
                           input logic [15:0] exp);
    daddr = addr;
    we    = 1'b0;
    #1;
    checkOutput(tag, ddatain, exp);
  endtask

  task automatic drainCheck(input string tag, input logic [15:0] exp);
    #1;
    checkOutput({tag, "_valid"}, {15'd0, out_valid}, 16'h0001);
    checkOutput({tag, "_data"}, out_data, exp);
    @(negedge clk);
  endtask

  initial begin
    applyStimulus(16'h0000, 16'h0000, 1'b0, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    readCheck("rst_stat", STAT, 16'h0001);
    checkOutput("rst_valid", {15'd0, out_valid}, 16'h0000);
    checkOutput("rst_data", out_data, 16'h0000);
    rst_n = 1'b1;
    readCheck("rst_tmr", TMR, 16'h0000);

    $display("[TB] RAM access");
    writeWord(16'd5, 16'h1234);
    readCheck("ram5", 16'd5, 16'h1234);
    writeWord(16'd0, 16'h1111);
    writeWord(16'hFF00, 16'h5555);
    readCheck("unmapped_rd", 16'hFF00, 16'h0000);
    readCheck("ram0_kept", 16'd0, 16'h1111);
    readCheck("txd_rd", TXD, 16'h0000);

    $display("[TB] FIFO order");
    out_ready = 1'b0;
    writeWord(TXD, 16'h00A1);
    writeWord(TXD, 16'h00A2);
    writeWord(TXD, 16'h00A3);
    readCheck("stat3", STAT, 16'h0030);
    applyStimulus(16'd5, 16'h0000, 1'b0, 1'b1);
    drainCheck("ord0", 16'h00A1);
    drainCheck("ord1", 16'h00A2);
    drainCheck("ord2", 16'h00A3);
    checkOutput("ord_empty", {15'd0, out_valid}, 16'h0000);
    readCheck("stat_empty", STAT, 16'h0001);

    $display("[TB] Overflow");
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) writeWord(TXD, 16'h00B0 + 16'(i));
    readCheck("stat_full", STAT, 16'h0042);
    writeWord(TXD, 16'h00B4);
    readCheck("stat_ovf", STAT, 16'h0046);
    writeWord(STAT, 16'h0000);
    readCheck("stat_clr", STAT, 16'h0042);
    applyStimulus(16'd5, 16'h0000, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) drainCheck($sformatf("ovf_drain%0d", i), 16'h00B0 + 16'(i));
    checkOutput("ovf_lost", {15'd0, out_valid}, 16'h0000);

    $display("[TB] Full with simultaneous pop");
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) writeWord(TXD, 16'h00C0 + 16'(i));
    applyStimulus(TXD, 16'hBEEF, 1'b1, 1'b1);
    @(negedge clk);
    applyStimulus(STAT, 16'h0000, 1'b0, 1'b0);
    readCheck("fullpop_stat", STAT, 16'h0042);
    applyStimulus(16'd5, 16'h0000, 1'b0, 1'b1);
    drainCheck("fp0", 16'h00C1);
    drainCheck("fp1", 16'h00C2);
    drainCheck("fp2", 16'h00C3);
    drainCheck("fp3", 16'hBEEF);
    checkOutput("fp_empty", {15'd0, out_valid}, 16'h0000);

    $display("[TB] Timer");
    out_ready = 1'b0;
    writeWord(TMR, 16'hFFFE);
    readCheck("tmr_load", TMR, 16'hFFFE);
    @(negedge clk);
    readCheck("tmr_ffff", TMR, 16'hFFFF);
    @(negedge clk);
    readCheck("tmr_wrap", TMR, 16'h0000);

    $display("[TB] Reset mid-operation");
    for (int i = 0; i < 3; i++) writeWord(TXD, 16'h00D0 + 16'(i));
    writeWord(TMR, 16'h0100);
    readCheck("tmr_0100", TMR, 16'h0100);
    readCheck("pre_rst_stat", STAT, 16'h0030);
    out_ready = 1'b1;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("mid_rst_valid", {15'd0, out_valid}, 16'h0000);
    checkOutput("mid_rst_data", out_data, 16'h0000);
    readCheck("mid_rst_stat", STAT, 16'h0001);
    readCheck("mid_rst_tmr0", TMR, 16'h0000);
    @(negedge clk);
    readCheck("mid_rst_tmr1", TMR, 16'h0001);
    @(negedge clk);
    readCheck("mid_rst_tmr2", TMR, 16'h0002);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
